// File: rtl/rxadc_cap_ctrl_pkg.sv
// rxadc_cap_ctrl_pkg: shared capture-state encodings and SPI register addresses
package rxadc_cap_ctrl_pkg;
   typedef enum logic [1:0] {
      CAP_IDLE = 2'd0,
      CAP_CAPT = 2'd1,
      CAP_DONE = 2'd2
   } cap_state_t;
   localparam logic [7:0] SPI_ADDR_ID     = 8'h00;
   localparam logic [7:0] SPI_ADDR_CNT    = 8'h01;
   localparam logic [7:0] SPI_ADDR_TRIG   = 8'h03;
   localparam logic [7:0] SPI_ADDR_FREQ   = 8'h10;
   localparam logic [7:0] SPI_ADDR_DACMUX = 8'h11;
endpackage

// File: rtl/rxadc_cap_addr.sv
// rxadc_cap_addr: capture address counter with length clamp and last-address compare
module rxadc_cap_addr #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          inc,
   input  logic [15:0]   cnt,
   output logic [AW-1:0] addr,
   output logic          empty,
   output logic          last
);
   localparam int unsigned DEPTH = 2 ** AW;
   logic [AW:0] n, len, ctr;
   // clamp the requested count to the buffer depth; one extra bit keeps a full buffer from wrapping
   always_comb n = (32'(cnt) > DEPTH) ? (AW+1)'(DEPTH) : (AW+1)'(cnt);
   assign empty = (n == '0);
   assign last  = (ctr == len - 1'b1);
   assign addr  = ctr[AW-1:0];
   // length is latched only on the arming cycle so later cnt changes are ignored
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ctr <= '0;
         len <= '0;
      end else if (load) begin
         ctr <= '0;
         len <= n;
      end else if (inc) begin
         ctr <= ctr + 1'b1;
      end
endmodule

// File: rtl/rxadc_cap_ctrl.sv
// rxadc_cap_ctrl: trigger-armed ADC capture sequencer; define RXADC_CAP_OTR_EN for sticky over-range
module rxadc_cap_ctrl
   import rxadc_cap_ctrl_pkg::*;
#(
   parameter int AW = 10,
   parameter int DW = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          trig,
   input  logic [15:0]   cnt,
   input  logic          in_valid,
   input  logic [DW-1:0] in_dat,
   input  logic          in_otr,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_dat,
   output logic          busy,
   output logic          done,
   output logic          ovr
);
   cap_state_t    state;
   logic          trig_d, seen_low, rise, load, inc, empty, last;
   logic [AW-1:0] addr;
   // a held-high trigger across reset must not arm: require a low level first
   assign rise = trig & ~trig_d & seen_low;
   assign load = (state == CAP_IDLE) & rise;
   assign inc  = (state == CAP_CAPT) & trig & in_valid;
   rxadc_cap_addr #(.AW(AW)) u_addr (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .inc   (inc),
      .cnt   (cnt),
      .addr  (addr),
      .empty (empty),
      .last  (last)
   );
   // sequencer with registered write port and status; done leaves on the delayed trigger
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state    <= CAP_IDLE;
         trig_d   <= 1'b0;
         seen_low <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_dat   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         trig_d   <= trig;
         seen_low <= seen_low | ~trig;
         wr_en    <= 1'b0;
         case (state)
            CAP_IDLE:
               if (rise) begin
                  state <= empty ? CAP_DONE : CAP_CAPT;
                  busy  <= ~empty;
                  done  <= empty;
               end
            CAP_CAPT:
               if (!trig) begin
                  state <= CAP_IDLE;
                  busy  <= 1'b0;
               end else if (in_valid) begin
                  wr_en   <= 1'b1;
                  wr_addr <= addr;
                  wr_dat  <= in_dat;
                  if (last) state <= CAP_DONE;
               end
            CAP_DONE:
               if (!trig_d) begin
                  state <= CAP_IDLE;
                  done  <= 1'b0;
               end else begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end
            default: state <= CAP_IDLE;
         endcase
      end
`ifdef RXADC_CAP_OTR_EN
   // sticky over-range, updated only on capture writes and cleared when a capture arms
   always_ff @(posedge clk or posedge reset)
      if (reset) ovr <= 1'b0;
      else if (load && !empty) ovr <= 1'b0;
      else if (inc) ovr <= ovr | in_otr;
`else
   logic unused_otr;
   assign unused_otr = in_otr;
   assign ovr = 1'b0;
`endif
endmodule

// File: tb/tb_rxadc_cap_ctrl.sv
// tb_rxadc_cap_ctrl: randomized directed bench for the capture sequencer
module tb_rxadc_cap_ctrl;
   localparam int AW = 10;
   localparam int DW = 10;
   localparam int NC = 20000;
   localparam bit OTR =
`ifdef RXADC_CAP_OTR_EN
      1'b1;
`else
      1'b0;
`endif
   typedef struct {int c; int a; int d; bit o;} wr_t;
   logic clk = 1'b0, reset = 1'b1, trig = 1'b0, in_valid = 1'b0, in_otr = 1'b0;
   logic [15:0] cnt = '0;
   logic [DW-1:0] in_dat = '0;
   logic wr_en, busy, done, ovr;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_dat;
   int cyc = 0, total = 0, passes = 0;
   wr_t wlog[$];
   bit done_at[NC], busy_at[NC], ovr_at[NC];

   rxadc_cap_ctrl #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .trig(trig), .cnt(cnt), .in_valid(in_valid),
      .in_dat(in_dat), .in_otr(in_otr), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_dat(wr_dat), .busy(busy), .done(done), .ovr(ovr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (cyc < NC) begin
         done_at[cyc] = done;
         busy_at[cyc] = busy;
         ovr_at[cyc]  = ovr;
      end
      if (wr_en) wlog.push_back('{cyc, int'(wr_addr), int'(wr_dat), ovr});
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // mode: 0 valid every cycle, 3 every third cycle, 1 random; abort_n<0 means no abort
   task automatic run(input string tag, input int cv, input int mode, input int abort_n,
                      input int dat_fix, input int otr_idx);
      int n, t0, k, c_last, base, caps, extra, abort_cyc, fall, bad;
      bit aborted, any_otr, cap, seen_done;
      wr_t exp[$];
      n = (cv == 0) ? 0 : (cv > 2 ** AW) ? 2 ** AW : cv;
      trig = 0;
      in_valid = 0;
      repeat (3) tick();
      base = wlog.size();
      tick();
      t0 = cyc;
      trig = 1;
      cnt = 16'(cv);
      in_valid = 1'($urandom);
      in_dat = DW'($urandom);
      in_otr = 1'($urandom);
      caps = 0; k = 0; extra = 0; c_last = t0; aborted = 0; any_otr = 0; abort_cyc = 0;
      while (extra < 8) begin
         tick();
         k++;
         cnt = 16'($urandom);
         if (abort_n >= 0 && caps == abort_n && !aborted) begin
            trig = 0;
            aborted = 1;
            abort_cyc = cyc;
         end
         in_valid = (mode == 0) ? 1'b1 : (mode == 3) ? (k % 3 == 0) : 1'($urandom);
         in_dat = (dat_fix >= 0) ? DW'(dat_fix) : DW'($urandom);
         cap = in_valid && trig && caps < n;
         in_otr = cap ? (caps == otr_idx) : 1'($urandom);
         if (cap) begin
            any_otr |= in_otr;
            exp.push_back('{cyc + 1, caps, int'(in_dat), any_otr & OTR});
            caps++;
            c_last = cyc;
         end
         if (caps == n || aborted) extra++;
      end
      in_valid = 0;
      chk({tag, "_nwr"}, 64'(wlog.size() - base), 64'(exp.size()));
      bad = 0;
      for (int i = 0; i < exp.size() && base + i < wlog.size(); i++)
         if (wlog[base+i] != exp[i]) bad++;
      chk({tag, "_wrseq"}, 64'(bad), 0);
      if (n > 0) begin
         chk({tag, "_busy_start"}, 64'(busy_at[t0+1]), 1);
         chk({tag, "_ovr_clr"}, 64'(ovr_at[t0+1]), 0);
      end
      if (aborted) begin
         seen_done = 0;
         for (int c = t0; c <= cyc; c++) seen_done |= done_at[c];
         chk({tag, "_abort_busy"}, 64'(busy_at[abort_cyc+1]), 0);
         chk({tag, "_abort_nodone"}, 64'(seen_done), 0);
      end else begin
         int lx;
         lx = (n == 0) ? t0 + 1 : c_last + 2;
         chk({tag, "_done_pre"}, 64'(done_at[lx-1]), 0);
         chk({tag, "_done_rise"}, 64'(done_at[lx]), 1);
         chk({tag, "_busy_end"}, 64'(busy_at[lx]), 0);
         chk({tag, "_ovr_hold"}, 64'(ovr), 64'(any_otr & OTR));
         tick();
         trig = 0;
         fall = cyc;
         repeat (3) tick();
         chk({tag, "_done_hold"}, 64'(done_at[fall+1]), 1);
         chk({tag, "_done_clr"}, 64'(done_at[fall+2]), 0);
      end
   endtask

   initial begin
      int base;
      repeat (2) tick();
      chk("reset_outs", 64'({wr_en, wr_addr, wr_dat, busy, done, ovr}), 0);
      reset = 0;
      run("full1000", 1000, 0, -1, 950, -1);
      run("clamp5000", 5000, 3, -1, -1, -1);
      run("zero", 0, 1, -1, -1, -1);
      run("abort40", 100, 0, 40, -1, -1);
      run("otr7", 50, 1, -1, -1, 7);
      run("retrig", 20, 1, -1, -1, -1);
      for (int r = 0; r < 4; r++) run("rand", $urandom_range(1, 60), 1, -1, -1, $urandom_range(0, 20));
      trig = 0;
      repeat (3) tick();
      tick();
      trig = 1;
      cnt = 100;
      in_valid = 1;
      repeat (20) tick();
      chk("pre_reset_busy", 64'(busy), 1);
      #1 reset = 1;
      #1 chk("async_reset_outs", 64'({wr_en, wr_addr, wr_dat, busy, done, ovr}), 0);
      tick();
      reset = 0;
      base = wlog.size();
      repeat (10) tick();
      chk("held_trig_nowr", 64'(wlog.size() - base), 0);
      chk("held_trig_idle", 64'({busy, done}), 0);
      run("post_reset", 3, 0, -1, -1, -1);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
